// File: rtl/hw2_win_acc_if.sv
// Sample/result bus for hw2_win_acc: samples in from hw2_pipe, window statistics out.
// master drives samples and consumes results; slave is the accumulator.
interface hw2_win_acc_if #(
    parameter int WIDTH = 16,
    parameter int SUM_W = 18
);
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             clear;
    logic             out_ready;
    logic             out_valid;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic             ovf;

    modport master (
        output d, d_valid, clear, out_ready,
        input  out_valid, sum, max, min, ovf
    );

    modport slave (
        input  d, d_valid, clear, out_ready,
        output out_valid, sum, max, min, ovf
    );
endinterface

// File: rtl/hw2_win_acc.sv
// Windowed sum/max/min accumulator for hw2_pipe results; never back-pressures its input.
// Define HW2_WIN_ACC_SAT_EN to saturate the sum instead of wrapping modulo 2^SUM_W.
module hw2_win_acc #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 4,
    parameter int SUM_W  = 18
) (
    input  logic         clk,
    input  logic         reset,
    hw2_win_acc_if.slave bus
);
    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FILL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rmax_q, rmax_d;
    logic [WIDTH-1:0] rmin_q, rmin_d;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic             ovf_q, ovf_d;

    logic [SUM_W-1:0] nacc;
    logic [WIDTH-1:0] nmax;
    logic [WIDTH-1:0] nmin;

    function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                                 input logic [WIDTH-1:0] b);
`ifdef HW2_WIN_ACC_SAT_EN
        logic [SUM_W:0] t;
        t = {1'b0, a} + (SUM_W + 1)'(b);
        return t[SUM_W] ? '1 : t[SUM_W-1:0];
`else
        return a + SUM_W'(b);
`endif
    endfunction

    always_comb begin
        nacc = acc_add(acc_q, bus.d);
        nmax = (bus.d > rmax_q) ? bus.d : rmax_q;
        nmin = (bus.d < rmin_q) ? bus.d : rmin_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        rmax_d      = rmax_q;
        rmin_d      = rmin_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        max_d       = max_q;
        min_d       = min_q;
        ovf_d       = ovf_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // clear wins over a sample on the same edge and leaves the output register alone
        if (bus.clear) begin
            state_d = EMPTY;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (bus.d_valid) begin
            if (state_q == EMPTY) begin
                acc_d   = SUM_W'(bus.d);
                rmax_d  = bus.d;
                rmin_d  = bus.d;
                cnt_d   = CNT_W'(1);
                state_d = FILL;
            end else if (cnt_q == LAST) begin
                sum_d       = nacc;
                max_d       = nmax;
                min_d       = nmin;
                out_valid_d = 1'b1;
                if (out_valid_q && !bus.out_ready) begin
                    ovf_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = EMPTY;
            end else begin
                acc_d  = nacc;
                rmax_d = nmax;
                rmin_d = nmin;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            acc_q       <= '0;
            rmax_q      <= '0;
            rmin_q      <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            max_q       <= '0;
            min_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            rmax_q      <= rmax_d;
            rmin_q      <= rmin_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            min_q       <= min_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.max       = max_q;
    assign bus.min       = min_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_hw2_win_acc.sv
// Bench for hw2_win_acc (WIDTH=16, WINDOW=4, SUM_W=17): window table plus handshake/abort sequences.
module tb_hw2_win_acc;
    localparam int WIDTH = 16;
    localparam int SUM_W = 17;
`ifdef HW2_WIN_ACC_SAT_EN
    localparam logic [SUM_W-1:0] FULL_SUM = 17'd131071;
`else
    localparam logic [SUM_W-1:0] FULL_SUM = 17'd131068;
`endif

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] mn;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] d [6];
        logic [5:0]       dv;
        res_t             exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    res_t sbq[$];

    hw2_win_acc_if #(.WIDTH(WIDTH), .SUM_W(SUM_W)) bus ();

    hw2_win_acc #(.WIDTH(WIDTH), .WINDOW(4), .SUM_W(SUM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [WIDTH-1:0] dd, input logic dv, input logic clr, input logic rdy);
        @(posedge clk);
        #1;
        bus.d         = dd;
        bus.d_valid   = dv;
        bus.clear     = clr;
        bus.out_ready = rdy;
    endtask

    task automatic push(input logic [SUM_W-1:0] s, input logic [WIDTH-1:0] mx, input logic [WIDTH-1:0] mn);
        res_t r;
        r.sum = s;
        r.mx  = mx;
        r.mn  = mn;
        sbq.push_back(r);
    endtask

    // Scoreboard: every transfer must match the oldest expected window.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got sum %0d, expected no output", bus.sum);
            end else begin
                res_t r;
                r = sbq.pop_front();
                chk("sb_sum", 32'(bus.sum), 32'(r.sum));
                chk("sb_max", 32'(bus.max), 32'(r.mx));
                chk("sb_min", 32'(bus.min), 32'(r.mn));
            end
        end
    end

    initial begin
        vec_t vecs [6];
        vecs[0].d = '{16'd6, 16'd15, 16'd1, 16'd10, 16'd0, 16'd0};
        vecs[0].dv = 6'b001111;  vecs[0].exp = '{17'd32, 16'd15, 16'd1};
        vecs[1].d = '{16'd3, 16'd99, 16'd4, 16'd0, 16'd5, 16'd2};
        vecs[1].dv = 6'b110101;  vecs[1].exp = '{17'd14, 16'd5, 16'd2};
        vecs[2].d = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 16'd9};
        vecs[2].dv = 6'b001111;  vecs[2].exp = '{17'd0, 16'd0, 16'd0};
        vecs[3].d = '{16'd65535, 16'd0, 16'd1, 16'd65534, 16'd0, 16'd0};
        vecs[3].dv = 6'b001111;  vecs[3].exp = '{17'd131070, 16'd65535, 16'd0};
        vecs[4].d = '{16'd65535, 16'd65535, 16'd65535, 16'd65535, 16'd0, 16'd0};
        vecs[4].dv = 6'b001111;  vecs[4].exp = '{FULL_SUM, 16'd65535, 16'd65535};
        vecs[5].d = '{16'd100, 16'd7, 16'd200, 16'd50, 16'd7, 16'd300};
        vecs[5].dv = 6'b101101;  vecs[5].exp = '{17'd650, 16'd300, 16'd50};

        bus.d = '0; bus.d_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b0;

        // Reset held with random traffic
        repeat (4) begin
            @(negedge clk);
            bus.d       = WIDTH'($urandom);
            bus.d_valid = 1'($urandom);
        end
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_max", 32'(bus.max), 0);
        chk("rst_min", 32'(bus.min), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.d_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            push(vecs[v].exp.sum, vecs[v].exp.mx, vecs[v].exp.mn);
            for (int c = 0; c < 6; c++) drv(vecs[v].d[c], vecs[v].dv[c], 1'b0, 1'b1);
        end
        drv(0, 0, 0, 1);
        drv(0, 0, 0, 1);
        chk("tbl_valid_dropped", 32'(bus.out_valid), 0);

        // Backpressure and overwrite
        for (int i = 0; i < 4; i++) drv(1, 1, 0, 0);
        drv(0, 0, 0, 0);
        chk("bp_valid1", 32'(bus.out_valid), 1);
        chk("bp_sum1", 32'(bus.sum), 4);
        chk("bp_ovf1", 32'(bus.ovf), 0);
        for (int i = 0; i < 4; i++) drv(2, 1, 0, 0);
        drv(0, 0, 0, 0);
        chk("bp_sum2", 32'(bus.sum), 8);
        chk("bp_ovf2", 32'(bus.ovf), 1);
        chk("bp_valid2", 32'(bus.out_valid), 1);
        push(17'd8, 16'd2, 16'd2);
        drv(0, 0, 0, 1);
        drv(0, 0, 0, 0);
        chk("bp_valid_drop", 32'(bus.out_valid), 0);
        chk("bp_ovf_sticky", 32'(bus.ovf), 1);
        drv(0, 0, 1, 0);
        drv(0, 0, 0, 0);
        chk("clr_ovf", 32'(bus.ovf), 0);
        chk("clr_sum_kept", 32'(bus.sum), 8);

        // Completion on the same edge as a transfer of the previous result
        for (int i = 0; i < 4; i++) drv(5, 1, 0, 0);
        drv(1, 1, 0, 0);
        drv(2, 1, 0, 0);
        drv(3, 1, 0, 0);
        push(17'd20, 16'd5, 16'd5);
        drv(4, 1, 0, 1);
        push(17'd10, 16'd4, 16'd1);
        drv(0, 0, 0, 1);
        drv(0, 0, 0, 0);
        chk("simul_ovf", 32'(bus.ovf), 0);
        chk("simul_valid", 32'(bus.out_valid), 0);

        // Asynchronous reset mid-window
        drv(7, 1, 0, 1);
        drv(8, 1, 0, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_sum", 32'(bus.sum), 0);
        chk("arst_max", 32'(bus.max), 0);
        chk("arst_valid", 32'(bus.out_valid), 0);
        bus.d_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        push(17'd10, 16'd4, 16'd1);
        for (int i = 1; i <= 4; i++) drv(WIDTH'(i), 1, 0, 1);

        // Clear mid-window; the sample on the clear edge is dropped
        drv(7, 1, 0, 1);
        drv(8, 1, 0, 1);
        drv(50, 1, 1, 1);
        push(17'd10, 16'd4, 16'd1);
        for (int i = 1; i <= 4; i++) drv(WIDTH'(i), 1, 0, 1);
        drv(0, 0, 0, 1);

        for (int t = 0; t < 20 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hw2_win_acc.md
# hw2_win_acc

Windowed result accumulator that sits directly downstream of `hw2_pipe` and consumes its 16-bit result `d`. It collects `WINDOW` valid results and reports three statistics for each window: their sum, maximum and minimum. Results are presented on a valid/ready output port. Because `hw2_pipe` cannot stall, this block never back-pressures its input; it flags lost results instead.

## Interface
Parameters:
- `WIDTH`, default 16: input sample width (matches `hw2_pipe` output `d`).
- `WINDOW`, default 4: samples per window; legal range 2..16.
- `SUM_W`, default 18: sum width; must be ≥ `WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `d`  in  `WIDTH`  sample from `hw2_pipe`, unsigned.
- `d_valid`  in  1  `d` is sampled on this edge.
- `clear`  in  1  synchronous; discards the partial window and clears `ovf`.
- `out_ready`  in  1  consumer accepts the result.
- `out_valid`  out  1  `sum`/`max`/`min` hold a complete window.
- `sum`  out  `SUM_W`  sum of the window's samples.
- `max`  out  `WIDTH`  largest sample in the window.
- `min`  out  `WIDTH`  smallest sample in the window.
- `ovf`  out  1  sticky: an unconsumed result was overwritten.

## Operation
- Reset values:
  - `out_valid`=0, `sum`=0, `max`=0, `min`=0, `ovf`=0.
  - Sample count=0; FSM enters EMPTY.
- FSM states:
  - EMPTY (count 0). On `d_valid`: load acc=`d`, runmax=`d`, runmin=`d`, count=1 → FILL.
  - FILL (count 1..`WINDOW`-1). On `d_valid`: acc+=`d`, update runmax/runmin (unsigned compare), count+=1.
  - When the incoming sample is the `WINDOW`-th: load the output register with the final acc/runmax/runmin including that sample, set `out_valid`=1, → EMPTY.
- `d_valid`=0: no state change.
- `clear`:
  - Has priority over `d_valid`; the sample on that edge is dropped.
  - → EMPTY, count=0, `ovf`=0.
  - The output register and `out_valid` are untouched.
- Output handshake:
  - A transfer occurs on an edge where `out_valid`&&`out_ready`; `out_valid` then drops unless a new window completes on the same edge.
  - Outputs are stable while `out_valid`=1 and not consumed.
- Simultaneous events:
  - Window completes with `out_valid`=1 and `out_ready`=1: the old result transfers, the new one loads, `out_valid` stays 1, `ovf` unchanged.
  - Window completes with `out_valid`=1 and `out_ready`=0: the new result overwrites the old and `ovf` is set to 1.
- `ovf` clears only on `reset` or `clear`.
- Arithmetic: the accumulator is `SUM_W` bits wide. Overflow behaviour is set by the Configuration macro.

## Timing
- Zero-bubble input: `d_valid` may be 1 every cycle indefinitely.
- Latency: the output register updates on the same rising edge that samples the `WINDOW`-th `d`. Results are visible in the following cycle.
- Throughput: one window per `WINDOW` cycles at full input rate.
- `reset` asynchronous: asserting it mid-window immediately forces all reset values. The partial window and any pending result are lost.
- The first edge after `reset` deasserts may sample `d` normally.

## Configuration
- `HW2_WIN_ACC_SAT_EN` defined:
  - The accumulator saturates at 2^`SUM_W`-1 and stays there for the rest of the window.
  - The saturated value is reported in `sum`.
- Not defined: the accumulator wraps modulo 2^`SUM_W`.
- `max`/`min` are unaffected either way.

## Test plan
- Reset: hold `reset`=1 with random `d`/`d_valid` → `out_valid`=0, `sum`=0, `max`=0, `min`=0, `ovf`=0.
- Basic: `WINDOW`=4, `out_ready`=1, `d`=6,15,1,10 on consecutive edges → after the 4th edge `sum`=32, `max`=15, `min`=1, `out_valid`=1 for exactly one cycle.
- Gapped input: `d`=3,(invalid 99),4,(invalid 0),5,2 → `sum`=14, `max`=5, `min`=2; invalid values are ignored.
- Backpressure:
  - Hold `out_ready`=0; run window 1,1,1,1 then window 2,2,2,2 → `sum`=8, `ovf`=1, `out_valid` still 1.
  - Pulse `out_ready` → `out_valid` drops.
  - Pulse `clear` → `ovf`=0.
- Saturation, `SUM_W`=17, four samples of 65535:
  - With `HW2_WIN_ACC_SAT_EN` → `sum`=131071.
  - Without → `sum`=131068.
  - `max`=`min`=65535 in both builds.
- Mid-window abort:
  - Samples 7,8 then assert `reset` asynchronously (between edges) → outputs zero immediately.
  - Next samples 1,2,3,4 → `sum`=10, `min`=1, `max`=4.
  - Repeat with `clear` in place of `reset` → same result.
